// File: rtl/alu_issue_pkg.sv
// Shared widths, ALU op codes and the issue-register layout for the ALU issue stage.
// Also holds the operand read helper with its bypass from the in-flight ALU result.
package alu_issue_pkg;

    localparam int XPR_LEN      = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int ALU_OP_WIDTH = 4;
    localparam int NUM_REGS     = 1 << REG_ADDR_W;

    typedef logic [XPR_LEN-1:0]      xpr_t;
    typedef logic [REG_ADDR_W-1:0]   reg_addr_t;
    typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

    localparam alu_op_t ALU_OP_ADD  = 4'd0;
    localparam alu_op_t ALU_OP_SLL  = 4'd1;
    localparam alu_op_t ALU_OP_XOR  = 4'd4;
    localparam alu_op_t ALU_OP_SRL  = 4'd5;
    localparam alu_op_t ALU_OP_OR   = 4'd6;
    localparam alu_op_t ALU_OP_AND  = 4'd7;
    localparam alu_op_t ALU_OP_SEQ  = 4'd8;
    localparam alu_op_t ALU_OP_SNE  = 4'd9;
    localparam alu_op_t ALU_OP_SUB  = 4'd10;
    localparam alu_op_t ALU_OP_SRA  = 4'd11;
    localparam alu_op_t ALU_OP_SLT  = 4'd12;
    localparam alu_op_t ALU_OP_SGE  = 4'd13;
    localparam alu_op_t ALU_OP_SLTU = 4'd14;
    localparam alu_op_t ALU_OP_SGEU = 4'd15;

    typedef struct packed {
        alu_op_t   op;
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rd;
        logic      use_imm;
        xpr_t      imm;
    } issue_t;

    // The result being written back this cycle is newer than the regfile copy.
    function automatic xpr_t bypass_read(input reg_addr_t addr, input logic wb_pend,
                                         input reg_addr_t wb_addr, input xpr_t alu_rd,
                                         input xpr_t rf_data);
        if (addr == '0)
            return '0;
        else if (wb_pend && (wb_addr == addr))
            return alu_rd;
        else
            return rf_data;
    endfunction

endpackage

// File: rtl/alu_issue_regfile_2r1w.sv
// Integer register file: two asynchronous read ports, one synchronous write port.
// x0 is never written and always reads as zero; all entries clear on reset.
module regfile_2r1w
    import alu_issue_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    output logic [XPR_LEN-1:0]    rd1,
    output logic [XPR_LEN-1:0]    rd2,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [XPR_LEN-1:0]    wd
);

    xpr_t regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/alu_issue.sv
// Issue/operand/writeback stage around a single-cycle registered ALU.
// Decode handshake: an op transfers on a rising edge where in_valid and in_ready are both high.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ALU_OP_WIDTH-1:0] in_op,
    input  logic [REG_ADDR_W-1:0]   in_rs1_addr,
    input  logic [REG_ADDR_W-1:0]   in_rs2_addr,
    input  logic [REG_ADDR_W-1:0]   in_rd_addr,
    input  logic                    in_use_imm,
    input  logic [XPR_LEN-1:0]      in_imm,
    input  logic                    hold,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic [XPR_LEN-1:0]      alu_rs1,
    output logic [XPR_LEN-1:0]      alu_rs2,
    output logic                    alu_enable,
    input  logic [XPR_LEN-1:0]      alu_rd,
    output logic                    wb_valid,
    output logic [REG_ADDR_W-1:0]   wb_addr,
    output logic [XPR_LEN-1:0]      wb_data
);

    issue_t issue_q;
    logic   issue_valid;
    logic   wb_pend;
    logic   fire;
    logic   accept;
    xpr_t   rf_rs1;
    xpr_t   rf_rs2;

    assign fire     = issue_valid & ~hold;
    assign in_ready = ~issue_valid | ~hold;
    assign accept   = in_valid & in_ready;

    // wb_pend follows fires only, so a hold never cancels a result already in the ALU.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_q     <= '0;
            issue_valid <= 1'b0;
            wb_pend     <= 1'b0;
            wb_addr     <= '0;
        end else begin
            if (accept) begin
                issue_q.op      <= in_op;
                issue_q.rs1     <= in_rs1_addr;
                issue_q.rs2     <= in_rs2_addr;
                issue_q.rd      <= in_rd_addr;
                issue_q.use_imm <= in_use_imm;
                issue_q.imm     <= in_imm;
                issue_valid     <= 1'b1;
            end else if (fire) begin
                issue_valid <= 1'b0;
            end
            wb_pend <= fire;
            if (fire)
                wb_addr <= issue_q.rd;
        end
    end

    regfile_2r1w u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (issue_q.rs1),
        .ra2   (issue_q.rs2),
        .rd1   (rf_rs1),
        .rd2   (rf_rs2),
        .we    (wb_valid),
        .wa    (wb_addr),
        .wd    (alu_rd)
    );

    assign alu_enable = fire;
    assign alu_op     = issue_q.op;
    assign alu_rs1    = bypass_read(issue_q.rs1, wb_pend, wb_addr, alu_rd, rf_rs1);
    assign alu_rs2    = issue_q.use_imm ? issue_q.imm
                                        : bypass_read(issue_q.rs2, wb_pend, wb_addr, alu_rd, rf_rs2);

    assign wb_valid = wb_pend & (wb_addr != '0);
    assign wb_data  = alu_rd;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a registered ALU model closing the loop on alu_rd.
// Writeback data is also checked in order against an expected queue.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic      clk;
    logic      reset;
    logic      in_valid;
    logic      in_ready;
    alu_op_t   in_op;
    reg_addr_t in_rs1_addr;
    reg_addr_t in_rs2_addr;
    reg_addr_t in_rd_addr;
    logic      in_use_imm;
    xpr_t      in_imm;
    logic      hold;
    alu_op_t   alu_op;
    xpr_t      alu_rs1;
    xpr_t      alu_rs2;
    logic      alu_enable;
    xpr_t      alu_rd;
    logic      wb_valid;
    reg_addr_t wb_addr;
    xpr_t      wb_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    alu_issue dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rs1_addr (in_rs1_addr),
        .in_rs2_addr (in_rs2_addr),
        .in_rd_addr  (in_rd_addr),
        .in_use_imm  (in_use_imm),
        .in_imm      (in_imm),
        .hold        (hold),
        .alu_op      (alu_op),
        .alu_rs1     (alu_rs1),
        .alu_rs2     (alu_rs2),
        .alu_enable  (alu_enable),
        .alu_rd      (alu_rd),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // registered ALU model: result one cycle after enable, zero otherwise
    function automatic xpr_t alu_f(input alu_op_t op, input xpr_t a, input xpr_t b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            ALU_OP_ADD:  return a + b;
            ALU_OP_SLL:  return a << sh;
            ALU_OP_XOR:  return a ^ b;
            ALU_OP_SRL:  return a >> sh;
            ALU_OP_OR:   return a | b;
            ALU_OP_AND:  return a & b;
            ALU_OP_SEQ:  return {31'b0, a == b};
            ALU_OP_SNE:  return {31'b0, a != b};
            ALU_OP_SUB:  return a - b;
            ALU_OP_SRA:  return xpr_t'($signed(a) >>> sh);
            ALU_OP_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_OP_SGE:  return {31'b0, $signed(a) >= $signed(b)};
            ALU_OP_SLTU: return {31'b0, a < b};
            ALU_OP_SGEU: return {31'b0, a >= b};
            default:     return '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            alu_rd <= '0;
        else if (alu_enable)
            alu_rd <= alu_f(alu_op, alu_rs1, alu_rs2);
        else
            alu_rd <= '0;
    end

    // checking
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // scoreboard: every register-file write must match the next expected value
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0)
                chk("wb_unexpected", 32'(wb_addr), 32'hFFFF_FFFF);
            else
                chk("wb_sb_data", wb_data, exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_op(input alu_op_t op, input int rs1, input int rs2, input int rd,
                            input bit use_imm, input xpr_t imm);
        in_valid    = 1'b1;
        in_op       = op;
        in_rs1_addr = reg_addr_t'(rs1);
        in_rs2_addr = reg_addr_t'(rs2);
        in_rd_addr  = reg_addr_t'(rd);
        in_use_imm  = use_imm;
        in_imm      = imm;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        hold  = 1'b0;
        in_valid = 1'b0;
        in_op = '0;
        in_rs1_addr = '0;
        in_rs2_addr = '0;
        in_rd_addr = '0;
        in_use_imm = 1'b0;
        in_imm = '0;

        // reset state
        next_cycle();
        mid();
        chk("rst_alu_enable", 32'(alu_enable), 0);
        chk("rst_wb_valid",   32'(wb_valid), 0);
        chk("rst_wb_addr",    32'(wb_addr), 0);
        chk("rst_alu_op",     32'(alu_op), 0);
        chk("rst_in_ready",   32'(in_ready), 1);
        next_cycle();
        reset = 1'b0;

        // 1: ADD x1 = x0 + 5
        exp_q.push_back(32'd5);
        drive_op(ALU_OP_ADD, 0, 0, 1, 1'b1, 32'd5);
        mid();
        chk("t1_ready_after_reset", 32'(in_ready), 1);
        next_cycle();
        idle();
        mid();
        chk("t1_fire", 32'(alu_enable), 1);
        chk("t1_alu_op", 32'(alu_op), 32'(ALU_OP_ADD));
        chk("t1_alu_rs1", alu_rs1, 0);
        chk("t1_alu_rs2", alu_rs2, 5);
        next_cycle();
        mid();
        chk("t1_wb_valid", 32'(wb_valid), 1);
        chk("t1_wb_addr", 32'(wb_addr), 1);
        chk("t1_wb_data", wb_data, 5);
        next_cycle();
        drive_op(ALU_OP_ADD, 1, 0, 0, 1'b1, 32'd0);
        next_cycle();
        idle();
        mid();
        chk("t1_x1_readback", alu_rs1, 5);
        next_cycle();
        mid();
        chk("t1_probe_no_wb", 32'(wb_valid), 0);

        // 2: ADDI x1 = 7 ; ADD x2 = x1 + x1 back to back
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd14);
        next_cycle();
        drive_op(ALU_OP_ADD, 0, 0, 1, 1'b1, 32'd7);
        next_cycle();
        drive_op(ALU_OP_ADD, 1, 1, 2, 1'b0, 32'd0);
        mid();
        chk("t2_first_fire", 32'(alu_enable), 1);
        chk("t2_first_rs2", alu_rs2, 7);
        chk("t2_ready_while_fire", 32'(in_ready), 1);
        next_cycle();
        idle();
        mid();
        chk("t2_no_bubble", 32'(alu_enable), 1);
        chk("t2_bypass_rs1", alu_rs1, 7);
        chk("t2_bypass_rs2", alu_rs2, 7);
        chk("t2_wb_addr_x1", 32'(wb_addr), 1);
        next_cycle();
        mid();
        chk("t2_wb_addr_x2", 32'(wb_addr), 2);
        chk("t2_wb_data_x2", wb_data, 14);

        // 3: ADD x3 = x2 + 1 held for 3 cycles, OR x5 = 9 waiting behind it
        exp_q.push_back(32'd15);
        exp_q.push_back(32'd9);
        next_cycle();
        drive_op(ALU_OP_ADD, 2, 0, 3, 1'b1, 32'd1);
        next_cycle();
        hold = 1'b1;
        drive_op(ALU_OP_OR, 0, 0, 5, 1'b1, 32'd9);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("t3_hold_enable", 32'(alu_enable), 0);
            chk("t3_hold_ready", 32'(in_ready), 0);
            chk("t3_hold_op", 32'(alu_op), 32'(ALU_OP_ADD));
            chk("t3_hold_rs1", alu_rs1, 14);
            if (i < 2)
                next_cycle();
        end
        next_cycle();
        hold = 1'b0;
        mid();
        chk("t3_release_fire", 32'(alu_enable), 1);
        chk("t3_release_op", 32'(alu_op), 32'(ALU_OP_ADD));
        chk("t3_release_ready", 32'(in_ready), 1);
        next_cycle();
        idle();
        mid();
        chk("t3_next_op", 32'(alu_op), 32'(ALU_OP_OR));
        chk("t3_next_rs2", alu_rs2, 9);
        chk("t3_wb_data_x3", wb_data, 15);
        next_cycle();
        mid();
        chk("t3_wb_addr_x5", 32'(wb_addr), 5);
        chk("t3_wb_data_x5", wb_data, 9);

        // 4: SUB x0 = x1 - x1 ; ADD x3 = x0 + x0
        exp_q.push_back(32'd0);
        next_cycle();
        drive_op(ALU_OP_SUB, 1, 1, 0, 1'b0, 32'd0);
        next_cycle();
        drive_op(ALU_OP_ADD, 0, 0, 3, 1'b0, 32'd0);
        mid();
        chk("t4_sub_op", 32'(alu_op), 32'(ALU_OP_SUB));
        chk("t4_sub_rs2", alu_rs2, 7);
        next_cycle();
        idle();
        mid();
        chk("t4_x0_no_wb", 32'(wb_valid), 0);
        chk("t4_add_rs1", alu_rs1, 0);
        next_cycle();
        mid();
        chk("t4_wb_addr_x3", 32'(wb_addr), 3);
        chk("t4_wb_data_x3", wb_data, 0);

        // 5: x6 = 0x80000000 ; SRA x4 = x6 >>> 4 ; x8 = 1 ; SLTU x7 = x8 < 0xFFFFFFFF
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(32'hF800_0000);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
        next_cycle();
        drive_op(ALU_OP_ADD, 0, 0, 6, 1'b1, 32'h8000_0000);
        next_cycle();
        drive_op(ALU_OP_SRA, 6, 0, 4, 1'b1, 32'd4);
        next_cycle();
        drive_op(ALU_OP_ADD, 0, 0, 8, 1'b1, 32'd1);
        mid();
        chk("t5_sra_op", 32'(alu_op), 32'(ALU_OP_SRA));
        chk("t5_sra_rs1_bypass", alu_rs1, 32'h8000_0000);
        next_cycle();
        drive_op(ALU_OP_SLTU, 8, 0, 7, 1'b1, 32'hFFFF_FFFF);
        mid();
        chk("t5_wb_addr_x4", 32'(wb_addr), 4);
        chk("t5_wb_data_sra", wb_data, 32'hF800_0000);
        next_cycle();
        idle();
        mid();
        chk("t5_sltu_rs1", alu_rs1, 1);
        chk("t5_sltu_rs2", alu_rs2, 32'hFFFF_FFFF);
        next_cycle();
        mid();
        chk("t5_wb_addr_x7", 32'(wb_addr), 7);
        chk("t5_wb_data_sltu", wb_data, 1);

        // 6: reset in the cycle ADD x9 fires
        next_cycle();
        drive_op(ALU_OP_ADD, 0, 0, 9, 1'b1, 32'h55);
        next_cycle();
        idle();
        reset = 1'b1;
        mid();
        chk("t6_fire_in_reset", 32'(alu_enable), 1);
        next_cycle();
        reset = 1'b0;
        mid();
        chk("t6_no_wb", 32'(wb_valid), 0);
        chk("t6_enable_clear", 32'(alu_enable), 0);
        chk("t6_ready", 32'(in_ready), 1);
        next_cycle();
        drive_op(ALU_OP_ADD, 9, 1, 0, 1'b0, 32'd0);
        next_cycle();
        idle();
        mid();
        chk("t6_x9_zero", alu_rs1, 0);
        chk("t6_x1_cleared", alu_rs2, 0);
        next_cycle();
        mid();
        chk("t6_probe_no_wb", 32'(wb_valid), 0);

        next_cycle();
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
